// File: rtl/leading_zero_normalize_pkg.sv
// Shared constants and helpers for the leading/trailing zero normalizer.
//   LZC_FROM_LSB / LZC_FROM_MSB : scan-direction selectors for FROM_MSB
//   lzc_count_bits()            : width of a zero count for a given operand width
package lzc_pkg;

  localparam int LZC_FROM_LSB = 0;
  localparam int LZC_FROM_MSB = 1;

  // A zero count never exceeds WIDTH-1 (all-zero reports 0), so clog2 suffices.
  function automatic int lzc_count_bits(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/leading_zero_normalize_if.sv
// Handshake and payload bundle of the normalizer. Signal names are written
// from the normalizer's point of view (_i = into the block, _o = out of it).
//   slave  : the normalizer itself
//   master : the environment driving upstream and sinking downstream
interface leading_zero_normalize_if
  import lzc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int COUNT_BITS = lzc_count_bits(WIDTH),
  parameter int TAG_BITS   = 4
);

  logic                  valid_i;
  logic                  ready_o;
  logic [WIDTH-1:0]      data_i;
  logic [TAG_BITS-1:0]   tag_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [WIDTH-1:0]      data_o;
  logic [COUNT_BITS-1:0] count_o;
  logic                  not_all_zero_o;
  logic [TAG_BITS-1:0]   tag_o;

  modport slave (
    input  valid_i, data_i, tag_i, ready_i,
    output ready_o, valid_o, data_o, count_o, not_all_zero_o, tag_o
  );

  modport master (
    output valid_i, data_i, tag_i, ready_i,
    input  ready_o, valid_o, data_o, count_o, not_all_zero_o, tag_o
  );

endinterface

// File: rtl/leading_zero_normalize_lzc_scan.sv
// Combinational zero scan: counts consecutive zeros from the scan origin.
//   data_i         : operand
//   count_o        : zeros before the first 1 (0 when the operand is all zero)
//   not_all_zero_o : 1 when any bit of data_i is set
module lzc_scan
  import lzc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int COUNT_BITS = lzc_count_bits(WIDTH),
  parameter int FROM_MSB   = LZC_FROM_LSB
) (
  input  logic [WIDTH-1:0]      data_i,
  output logic [COUNT_BITS-1:0] count_o,
  output logic                  not_all_zero_o
);

  // Reorder so that bit 0 of scan_s is always the scan origin.
  logic [WIDTH-1:0] scan_s;

  for (genvar g = 0; g < WIDTH; g++) begin : g_order
    if (FROM_MSB == LZC_FROM_MSB) begin : g_msb
      assign scan_s[g] = data_i[WIDTH-1-g];
    end else begin : g_lsb
      assign scan_s[g] = data_i[g];
    end
  end

  // Priority search for the first set bit from the origin.
  always_comb begin
    count_o        = '0;
    not_all_zero_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!not_all_zero_o && scan_s[i]) begin
        not_all_zero_o = 1'b1;
        count_o        = COUNT_BITS'(i);
      end else begin
        not_all_zero_o = not_all_zero_o;
      end
    end
  end

endmodule

// File: rtl/leading_zero_normalize.sv
// Two-stage zero-count normalizer with valid/ready flow control.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : drops every in-flight operand, blocks acceptance this cycle
//   bus          : upstream valid/ready/data/tag, downstream valid/ready and
//                  normalized data, zero count, not_all_zero flag and tag
// S1 captures the operand with its scan result; S2 holds the shifted operand.
module leading_zero_normalize
  import lzc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int COUNT_BITS = lzc_count_bits(WIDTH),
  parameter int FROM_MSB   = LZC_FROM_LSB,
  parameter int TAG_BITS   = 4
) (
  input logic                     clk_i,
  input logic                     rst_i,
  input logic                     flush_i,
  leading_zero_normalize_if.slave bus
);

  logic                  s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]      s1_data_q;
  logic [COUNT_BITS-1:0] s1_count_q;
  logic                  s1_naz_q;
  logic [TAG_BITS-1:0]   s1_tag_q;

  logic                  s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]      s2_data_q, s2_data_d;
  logic [COUNT_BITS-1:0] s2_count_q;
  logic                  s2_naz_q;
  logic [TAG_BITS-1:0]   s2_tag_q;

  logic                  s1_load, s2_load;
  logic [COUNT_BITS-1:0] scan_count;
  logic                  scan_naz;

  lzc_scan #(
    .WIDTH      (WIDTH),
    .COUNT_BITS (COUNT_BITS),
    .FROM_MSB   (FROM_MSB)
  ) u_scan (
    .data_i         (bus.data_i),
    .count_o        (scan_count),
    .not_all_zero_o (scan_naz)
  );

  // Stage enables and next valid bits; an empty S1 refills even if S2 stalls.
  always_comb begin
    s2_load    = !s2_valid_q || bus.ready_i;
    s1_load    = !s1_valid_q || s2_load;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
      end else begin
        s2_valid_d = s2_valid_q;
      end
      if (s1_load) begin
        s1_valid_d = bus.valid_i;
      end else begin
        s1_valid_d = s1_valid_q;
      end
    end
  end

  // Normalizing shift; an all-zero operand has count 0 and stays zero.
  always_comb begin
    if (FROM_MSB == LZC_FROM_MSB) begin
      s2_data_d = s1_data_q << s1_count_q;
    end else begin
      s2_data_d = s1_data_q >> s1_count_q;
    end
  end

  // S1 register: operand, scan result and tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_count_q <= '0;
      s1_naz_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_data_q  <= bus.data_i;
        s1_count_q <= scan_count;
        s1_naz_q   <= scan_naz;
        s1_tag_q   <= bus.tag_i;
      end
    end
  end

  // S2 register: drives every downstream output directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_count_q <= '0;
      s2_naz_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_data_q  <= s2_data_d;
        s2_count_q <= s1_count_q;
        s2_naz_q   <= s1_naz_q;
        s2_tag_q   <= s1_tag_q;
      end
    end
  end

  assign bus.ready_o        = s1_load && !flush_i;
  assign bus.valid_o        = s2_valid_q;
  assign bus.data_o         = s2_data_q;
  assign bus.count_o        = s2_count_q;
  assign bus.not_all_zero_o = s2_naz_q;
  assign bus.tag_o          = s2_tag_q;

endmodule

// File: tb/tb_leading_zero_normalize.sv
// Bench for leading_zero_normalize: one LSB-origin and one MSB-origin instance
// share the same stimulus; a scoreboard holds expected results per accepted
// operand, and directed sequences pin latency, backpressure, flush and reset.
module tb_leading_zero_normalize;

  localparam int W  = 8;
  localparam int CB = 3;
  localparam int TB = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [CB-1:0] c;
    logic          n;
  } res_t;

  typedef struct packed {
    logic [TB-1:0] tag;
    res_t          l;
    res_t          m;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_s = 1'b1;
  logic          flush_s = 1'b0;
  logic          valid_s = 1'b0;
  logic          ready_s = 1'b1;
  logic [W-1:0]  data_s = '0;
  logic [TB-1:0] tag_s = '0;

  int total = 0;
  int bad   = 0;

  ent_t sbq[$];

  always #5 clk = ~clk;

  leading_zero_normalize_if #(.WIDTH(W), .COUNT_BITS(CB), .TAG_BITS(TB)) ifl ();
  leading_zero_normalize_if #(.WIDTH(W), .COUNT_BITS(CB), .TAG_BITS(TB)) ifm ();

  assign ifl.valid_i = valid_s;
  assign ifl.data_i  = data_s;
  assign ifl.tag_i   = tag_s;
  assign ifl.ready_i = ready_s;
  assign ifm.valid_i = valid_s;
  assign ifm.data_i  = data_s;
  assign ifm.tag_i   = tag_s;
  assign ifm.ready_i = ready_s;

  leading_zero_normalize #(.WIDTH(W), .COUNT_BITS(CB), .FROM_MSB(0), .TAG_BITS(TB)) dut_l (
    .clk_i(clk), .rst_i(rst_s), .flush_i(flush_s), .bus(ifl)
  );

  leading_zero_normalize #(.WIDTH(W), .COUNT_BITS(CB), .FROM_MSB(1), .TAG_BITS(TB)) dut_m (
    .clk_i(clk), .rst_i(rst_s), .flush_i(flush_s), .bus(ifm)
  );

  // Reference: walk the operand until the origin bit is set, counting steps.
  function automatic res_t ref_norm(input logic [W-1:0] x, input bit msb);
    res_t r;
    int n;
    logic [W-1:0] v;
    r = '0;
    n = 0;
    v = x;
    if (x == '0) return r;
    if (msb) begin
      while (v[W-1] == 1'b0) begin v = v << 1; n++; end
    end else begin
      while (v[0] == 1'b0) begin v = v >> 1; n++; end
    end
    r.d = v;
    r.c = n[CB-1:0];
    r.n = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] one;
    one = 1;
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return one << $urandom_range(0, W - 1);
      2:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard: checks every output transfer, hold stability and flush blocking.
  logic          hold_prev = 1'b0;
  logic [W-1:0]  prev_dl, prev_dm;
  logic [CB-1:0] prev_cl;
  logic [TB-1:0] prev_tag;

  always @(negedge clk) begin
    ent_t e;
    if (rst_s) begin
      sbq.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", ifl.valid_o, 1);
        check("hold_data_l", ifl.data_o, prev_dl);
        check("hold_data_m", ifm.data_o, prev_dm);
        check("hold_count_l", ifl.count_o, prev_cl);
        check("hold_tag", ifl.tag_o, prev_tag);
      end
      if (flush_s) begin
        check("flush_ready", ifl.ready_o, 0);
        sbq.delete();
      end else begin
        if (ifl.valid_o && ready_s) begin
          if (sbq.size() == 0) begin
            check("spurious_out", ifl.valid_o, 0);
          end else begin
            e = sbq.pop_front();
            check("tag", ifl.tag_o, e.tag);
            check("data_l", ifl.data_o, e.l.d);
            check("count_l", ifl.count_o, e.l.c);
            check("naz_l", ifl.not_all_zero_o, e.l.n);
            check("valid_m", ifm.valid_o, 1);
            check("data_m", ifm.data_o, e.m.d);
            check("count_m", ifm.count_o, e.m.c);
            check("naz_m", ifm.not_all_zero_o, e.m.n);
            check("tag_m", ifm.tag_o, e.tag);
          end
        end
        if (valid_s && ifl.ready_o) begin
          e.tag = tag_s;
          e.l   = ref_norm(data_s, 1'b0);
          e.m   = ref_norm(data_s, 1'b1);
          sbq.push_back(e);
        end
      end
      hold_prev = ifl.valid_o && !ready_s && !flush_s;
      prev_dl   = ifl.data_o;
      prev_dm   = ifm.data_o;
      prev_cl   = ifl.count_o;
      prev_tag  = ifl.tag_o;
    end
  end

  // Single operand through an idle pipe, with literal expectations for both origins.
  task automatic send_one(input logic [W-1:0] d, input logic [TB-1:0] t,
                          input logic [W-1:0] dl, input logic [CB-1:0] cl,
                          input logic [W-1:0] dm, input logic [CB-1:0] cm,
                          input logic nz);
    cyc();
    valid_s = 1'b1; data_s = d; tag_s = t; ready_s = 1'b1;
    cyc();
    valid_s = 1'b0;
    @(negedge clk);
    check("lat_early", ifl.valid_o, 0);
    cyc();
    @(negedge clk);
    check("lat_valid", ifl.valid_o, 1);
    check("lit_data_l", ifl.data_o, dl);
    check("lit_count_l", ifl.count_o, cl);
    check("lit_data_m", ifm.data_o, dm);
    check("lit_count_m", ifm.count_o, cm);
    check("lit_naz", ifl.not_all_zero_o, nz);
    check("lit_tag", ifl.tag_o, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    rst_s = 1'b0;
    @(negedge clk);
    check("rst_valid", ifl.valid_o, 0);
    check("rst_data", ifl.data_o, 0);
    check("rst_count", ifl.count_o, 0);
    check("rst_naz", ifl.not_all_zero_o, 0);
    check("rst_tag", ifl.tag_o, 0);
    check("rst_ready", ifl.ready_o, 1);

    send_one(8'b0010_1000, 4'hA, 8'b0000_0101, 3'd3, 8'b1010_0000, 3'd2, 1'b1);
    send_one(8'b0001_0110, 4'h3, 8'b0000_1011, 3'd1, 8'b1011_0000, 3'd3, 1'b1);
    send_one(8'h80,        4'h5, 8'h01,        3'd7, 8'h80,        3'd0, 1'b1);
    send_one(8'h00,        4'h6, 8'h00,        3'd0, 8'h00,        3'd0, 1'b0);
    send_one(8'h01,        4'h7, 8'h01,        3'd0, 8'h80,        3'd7, 1'b1);

    // Backpressure: tags 1,2,3 with downstream stalled for 4 cycles
    cyc(); ready_s = 1'b0; valid_s = 1'b1; tag_s = 4'd1; data_s = rand_data();
    @(negedge clk); check("bp_ready_a", ifl.ready_o, 1);
    cyc(); tag_s = 4'd2; data_s = rand_data();
    @(negedge clk); check("bp_ready_b", ifl.ready_o, 1);
    cyc(); tag_s = 4'd3; data_s = rand_data();
    @(negedge clk); check("bp_ready_drop", ifl.ready_o, 0);
    check("bp_tag_c", ifl.tag_o, 1);
    cyc();
    @(negedge clk); check("bp_ready_d", ifl.ready_o, 0);
    check("bp_tag_d", ifl.tag_o, 1);
    cyc(); ready_s = 1'b1;
    @(negedge clk); check("bp_rel_tag1", ifl.tag_o, 1);
    check("bp_rel_ready", ifl.ready_o, 1);
    cyc(); valid_s = 1'b0;
    @(negedge clk); check("bp_rel_tag2", ifl.tag_o, 2);
    check("bp_rel_v2", ifl.valid_o, 1);
    cyc();
    @(negedge clk); check("bp_rel_tag3", ifl.tag_o, 3);
    check("bp_rel_v3", ifl.valid_o, 1);
    cyc();
    @(negedge clk); check("bp_empty", ifl.valid_o, 0);

    // Flush with a simultaneous input
    cyc(); valid_s = 1'b1; tag_s = 4'd8; data_s = rand_data();
    cyc(); tag_s = 4'd9; data_s = rand_data();
    cyc(); tag_s = 4'hB; data_s = rand_data(); flush_s = 1'b1;
    @(negedge clk); check("fl_ready", ifl.ready_o, 0);
    cyc(); valid_s = 1'b0; flush_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("fl_quiet", ifl.valid_o, 0);
      cyc();
    end
    valid_s = 1'b1; tag_s = 4'hC; data_s = 8'h40;
    cyc(); valid_s = 1'b0;
    @(negedge clk); check("fl_lat_early", ifl.valid_o, 0);
    cyc();
    @(negedge clk); check("fl_lat_valid", ifl.valid_o, 1);
    check("fl_tag", ifl.tag_o, 4'hC);
    check("fl_count_l", ifl.count_o, 6);

    // Reset while both stages hold operands
    cyc(); ready_s = 1'b0; valid_s = 1'b1; tag_s = 4'hD; data_s = 8'h12;
    cyc(); tag_s = 4'hE; data_s = 8'h34;
    cyc(); valid_s = 1'b0; rst_s = 1'b1;
    cyc(); rst_s = 1'b0; ready_s = 1'b1;
    @(negedge clk);
    check("mr_valid", ifl.valid_o, 0);
    check("mr_data", ifl.data_o, 0);
    check("mr_count", ifl.count_o, 0);
    check("mr_naz", ifl.not_all_zero_o, 0);
    check("mr_tag", ifl.tag_o, 0);
    check("mr_ready", ifl.ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk); check("mr_no_stale", ifl.valid_o, 0);
    end

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc();
      valid_s = ($urandom_range(0, 9) < 7);
      ready_s = ($urandom_range(0, 9) < 7);
      flush_s = ($urandom_range(0, 99) == 0);
      rst_s   = ($urandom_range(0, 299) == 0);
      data_s  = rand_data();
      tag_s   = TB'($urandom);
    end
    cyc();
    valid_s = 1'b0; ready_s = 1'b1; flush_s = 1'b0; rst_s = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    check("drain_empty", sbq.size(), 0);
    check("drain_valid", ifl.valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
